// File: rtl/btle_adv_scheduler.sv
// Advertising-event sequencer: copies one PDU into the PHY octet memory,
// then transmits it on each enabled primary channel (37, 38, 39) in order.
module btle_adv_scheduler #(
  parameter int          CLK_FREQUENCE            = 16_000_000,
  parameter int          CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int          CRC_STATE_BIT_WIDTH      = 24,
  parameter int          INTERVAL_WIDTH           = 24,
  parameter int          GAP_CYCLES               = 16000,
  parameter int          TX_TIMEOUT_CYCLES        = 65535,
  parameter logic [7:0]  PREAMBLE                 = 8'hAA
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adv_enable,
  input  logic [INTERVAL_WIDTH-1:0]           adv_interval_cycles,
  input  logic [2:0]                          adv_chan_map,
  input  logic [5:0]                          pdu_len,
  output logic [5:0]                          pdu_buf_addr,
  input  logic [7:0]                          pdu_buf_data,
  output logic [5:0]                          tx_pdu_octet_mem_addr,
  output logic [7:0]                          tx_pdu_octet_mem_data,
  output logic                                tx_pdu_octet_mem_we,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
  output logic [31:0]                         tx_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit,
  output logic [7:0]                          tx_preamble,
  output logic                                tx_start,
  input  logic                                tx_iq_valid_last,
  output logic                                adv_busy,
  output logic                                event_done,
  output logic                                tx_timeout,
  output logic [2:0]                          dbg_state
);

  localparam int CNT_MAX0 = (GAP_CYCLES > TX_TIMEOUT_CYCLES) ? GAP_CYCLES : TX_TIMEOUT_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > 64) ? CNT_MAX0 : 64;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    LOAD          = 3'd1,
    CONFIG        = 3'd2,
    START         = 3'd3,
    WAIT_TX       = 3'd4,
    GAP           = 3'd5,
    WAIT_INTERVAL = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [INTERVAL_WIDTH-1:0]     int_cnt_q, int_cnt_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [2:0]                    map_q, map_d;
  logic [5:0]                    len_q, len_d;
  logic [1:0]                    idx_q, idx_d;
  logic                          stop_q, stop_d;
  logic [5:0]                    buf_addr_q, buf_addr_d;
  logic [5:0]                    mem_addr_q, mem_addr_d;
  logic                          mem_we_q, mem_we_d;
  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] chan_q, chan_d;
  logic [31:0]                   aa_q, aa_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] crc_q, crc_d;
  logic [7:0]                    pre_q, pre_d;
  logic                          tx_start_q, tx_start_d;
  logic                          busy_q;
  logic                          done_q, done_d;
  logic                          timeout_q, timeout_d;

  logic       start_event, enter_config, tx_done, timed_out, has_next;
  logic [1:0] first_idx, next_idx;

  always_comb begin
    first_idx = map_q[0] ? 2'd0 : (map_q[1] ? 2'd1 : 2'd2);
    has_next  = 1'b0;
    next_idx  = idx_q;
    if (idx_q == 2'd0 && map_q[1]) begin
      has_next = 1'b1;
      next_idx = 2'd1;
    end else if (idx_q != 2'd2 && map_q[2]) begin
      has_next = 1'b1;
      next_idx = 2'd2;
    end
  end

  // tx_start is a one-cycle request to the PHY; its one-cycle tx_iq_valid_last
  // reply is only sampled in WAIT_TX, so a reply during START is ignored.
  always_comb begin
    state_d      = state_q;
    int_cnt_d    = (state_q != IDLE && int_cnt_q != '0) ? int_cnt_q - INTERVAL_WIDTH'(1) : int_cnt_q;
    cnt_d        = cnt_q;
    map_d        = map_q;
    len_d        = len_q;
    idx_d        = idx_q;
    stop_d       = stop_q;
    buf_addr_d   = buf_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    tx_start_d   = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    start_event  = 1'b0;
    enter_config = 1'b0;
    timed_out    = (cnt_q == CNT_W'(TX_TIMEOUT_CYCLES - 1));
    tx_done      = tx_iq_valid_last || timed_out;
    unique case (state_q)
      IDLE: begin
        if (adv_enable && adv_chan_map != 3'b000) start_event = 1'b1;
      end
      LOAD: begin
        if (!adv_enable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(len_q)) begin
          state_d      = CONFIG;
          idx_d        = first_idx;
          enter_config = 1'b1;
        end else begin
          // The octet for address cnt_q arrives next cycle; write it then.
          mem_we_d   = 1'b1;
          mem_addr_d = cnt_q[5:0];
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) < CNT_W'(len_q)) buf_addr_d = cnt_q[5:0] + 6'd1;
        end
      end
      CONFIG: begin
        state_d    = START;
        tx_start_d = 1'b1;
        if (!adv_enable) stop_d = 1'b1;
      end
      START: begin
        state_d = WAIT_TX;
        cnt_d   = '0;
        if (!adv_enable) stop_d = 1'b1;
      end
      WAIT_TX: begin
        if (tx_done) begin
          timeout_d = !tx_iq_valid_last;
          cnt_d     = '0;
          if (stop_q || !adv_enable) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (has_next) begin
            state_d = GAP;
          end else begin
            state_d = WAIT_INTERVAL;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (!adv_enable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d      = CONFIG;
          idx_d        = next_idx;
          enter_config = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_INTERVAL: begin
        if (!adv_enable) state_d = IDLE;
        else if (int_cnt_q == '0) begin
          if (adv_chan_map != 3'b000) start_event = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_event) begin
      state_d    = LOAD;
      map_d      = adv_chan_map;
      len_d      = (pdu_len == 6'd0) ? 6'd1 : pdu_len;
      int_cnt_d  = adv_interval_cycles - INTERVAL_WIDTH'(1);
      cnt_d      = '0;
      buf_addr_d = 6'd0;
      stop_d     = 1'b0;
    end
  end

  always_comb begin
    chan_d = chan_q;
    aa_d   = aa_q;
    crc_d  = crc_q;
    pre_d  = pre_q;
    if (enter_config) begin
      chan_d = CHANNEL_NUMBER_BIT_WIDTH'(37) + CHANNEL_NUMBER_BIT_WIDTH'(idx_d);
      aa_d   = 32'h8E89BED6;
      crc_d  = CRC_STATE_BIT_WIDTH'(24'h555555);
      pre_d  = PREAMBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      int_cnt_q  <= '0;
      cnt_q      <= '0;
      map_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      buf_addr_q <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      chan_q     <= '0;
      aa_q       <= '0;
      crc_q      <= '0;
      pre_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      int_cnt_q  <= int_cnt_d;
      cnt_q      <= cnt_d;
      map_q      <= map_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      buf_addr_q <= buf_addr_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      chan_q     <= chan_d;
      aa_q       <= aa_d;
      crc_q      <= crc_d;
      pre_q      <= pre_d;
      tx_start_q <= tx_start_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Octet data comes straight from the buffer's registered read port.
  assign tx_pdu_octet_mem_data = mem_we_q ? pdu_buf_data : 8'd0;
  assign tx_pdu_octet_mem_addr = mem_addr_q;
  assign tx_pdu_octet_mem_we   = mem_we_q;
  assign pdu_buf_addr          = buf_addr_q;
  assign tx_channel_number     = chan_q;
  assign tx_access_address     = aa_q;
  assign tx_crc_state_init_bit = crc_q;
  assign tx_preamble           = pre_q;
  assign tx_start              = tx_start_q;
  assign adv_busy              = busy_q;
  assign event_done            = done_q;
  assign tx_timeout            = timeout_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_btle_adv_scheduler.sv
// Directed bench for btle_adv_scheduler with a source-buffer model and a
// PHY model that answers a configurable number of cycles after tx_start.
module tb_btle_adv_scheduler;

  logic        clk;
  logic        rst;
  logic        adv_enable;
  logic [23:0] adv_interval_cycles;
  logic [2:0]  adv_chan_map;
  logic [5:0]  pdu_len;
  logic [5:0]  pdu_buf_addr;
  logic [7:0]  pdu_buf_data;
  logic [5:0]  tx_pdu_octet_mem_addr;
  logic [7:0]  tx_pdu_octet_mem_data;
  logic        tx_pdu_octet_mem_we;
  logic [5:0]  tx_channel_number;
  logic [31:0] tx_access_address;
  logic [23:0] tx_crc_state_init_bit;
  logic [7:0]  tx_preamble;
  logic        tx_start;
  logic        tx_iq_valid_last;
  logic        adv_busy;
  logic        event_done;
  logic        tx_timeout;
  logic [2:0]  dbg_state;

  btle_adv_scheduler #(
    .GAP_CYCLES        (10),
    .TX_TIMEOUT_CYCLES (100)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .adv_enable            (adv_enable),
    .adv_interval_cycles   (adv_interval_cycles),
    .adv_chan_map          (adv_chan_map),
    .pdu_len               (pdu_len),
    .pdu_buf_addr          (pdu_buf_addr),
    .pdu_buf_data          (pdu_buf_data),
    .tx_pdu_octet_mem_addr (tx_pdu_octet_mem_addr),
    .tx_pdu_octet_mem_data (tx_pdu_octet_mem_data),
    .tx_pdu_octet_mem_we   (tx_pdu_octet_mem_we),
    .tx_channel_number     (tx_channel_number),
    .tx_access_address     (tx_access_address),
    .tx_crc_state_init_bit (tx_crc_state_init_bit),
    .tx_preamble           (tx_preamble),
    .tx_start              (tx_start),
    .tx_iq_valid_last      (tx_iq_valid_last),
    .adv_busy              (adv_busy),
    .event_done            (event_done),
    .tx_timeout            (tx_timeout),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment models ----------------
  logic [7:0] buf_mem [0:63];
  always @(posedge clk) pdu_buf_data <= buf_mem[pdu_buf_addr];

  int phy_delay = 0;
  int phy_cnt   = 0;
  always @(posedge clk) begin
    if (rst) phy_cnt <= 0;
    else if (tx_start) phy_cnt <= phy_delay;
    else if (phy_cnt != 0) phy_cnt <= phy_cnt - 1;
  end
  assign tx_iq_valid_last = (phy_cnt == 1);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  logic [13:0] exp_q[$];
  logic        wr_chk_en = 1'b0;
  int          wr_seen   = 0;
  int          start_ch_q[$];
  int          start_cyc_q[$];
  int          load_cyc_q[$];
  int          ed_cnt = 0, ed_cyc = 0;
  int          to_cnt = 0, to_cyc = 0;
  logic        gap_seen = 1'b0;
  logic [2:0]  prev_state = 3'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_pdu_octet_mem_we && wr_chk_en) begin
        wr_seen++;
        if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", {18'd0, tx_pdu_octet_mem_addr, tx_pdu_octet_mem_data},
                   {18'd0, exp_q.pop_front()});
      end
      if (tx_start) begin
        start_ch_q.push_back(int'(tx_channel_number));
        start_cyc_q.push_back(cyc);
      end
      if (event_done) begin
        ed_cnt++;
        ed_cyc = cyc;
      end
      if (tx_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (dbg_state == 3'd1 && prev_state != 3'd1) load_cyc_q.push_back(cyc);
      if (dbg_state == 3'd5) gap_seen = 1'b1;
    end
    prev_state = dbg_state;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    start_ch_q.delete();
    start_cyc_q.delete();
    load_cyc_q.delete();
    wr_seen  = 0;
    ed_cnt   = 0;
    to_cnt   = 0;
    gap_seen = 1'b0;
  endtask

  function automatic int q_at(ref int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic wait_ed(string tag, int budget);
    int n = 0;
    while (ed_cnt < 1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(ed_cnt >= 1), 32'd1);
  endtask

  task automatic wait_loads(string tag, int cnt, int budget);
    int n = 0;
    while (load_cyc_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(load_cyc_q.size() >= cnt), 32'd1);
  endtask

  task automatic stop_and_check_idle(string tag);
    adv_enable = 1'b0;
    tick();
    check(tag, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    adv_enable = 1'b0;
    adv_interval_cycles = 24'd0;
    adv_chan_map = 3'b000;
    pdu_len = 6'd0;
    for (int i = 0; i < 64; i++) buf_mem[i] = 8'(i * 7 + 3);
    buf_mem[0] = 8'hA0; buf_mem[1] = 8'h5B; buf_mem[2] = 8'hC3; buf_mem[3] = 8'h7E;
    repeat (3) tick();

    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_busy", 32'(adv_busy), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_we", 32'(tx_pdu_octet_mem_we), 32'd0);
    check("rst_preamble", 32'(tx_preamble), 32'd0);
    check("rst_aa", tx_access_address, 32'd0);
    rst = 1'b0;
    tick();

    // Full event on all three channels
    clear_logs();
    for (int i = 0; i < 4; i++) exp_q.push_back({6'(i), buf_mem[i]});
    wr_chk_en = 1'b1;
    pdu_len = 6'd4; adv_chan_map = 3'b111; adv_interval_cycles = 24'd2000; phy_delay = 50;
    adv_enable = 1'b1;
    wait_ed("t1_event_done_wait", 400);
    wr_chk_en = 1'b0;
    check("t1_wr_left", 32'(exp_q.size()), 32'd0);
    check("t1_wr_count", 32'(wr_seen), 32'd4);
    check("t1_start_count", 32'(start_ch_q.size()), 32'd3);
    check("t1_ch0", 32'(q_at(start_ch_q, 0)), 32'd37);
    check("t1_ch1", 32'(q_at(start_ch_q, 1)), 32'd38);
    check("t1_ch2", 32'(q_at(start_ch_q, 2)), 32'd39);
    check("t1_start_spacing", 32'(q_at(start_cyc_q, 1) - q_at(start_cyc_q, 0)), 32'd62);
    check("t1_done_latency", 32'(ed_cyc - q_at(load_cyc_q, 0)), 32'd181);
    check("t1_gap_seen", 32'(gap_seen), 32'd1);
    check("t1_no_timeout", 32'(to_cnt), 32'd0);
    wait_loads("t1_second_load_wait", 2, 2100);
    check("t1_interval", 32'(q_at(load_cyc_q, 1) - q_at(load_cyc_q, 0)), 32'd2000);
    check("t1_event_done_once", 32'(ed_cnt), 32'd1);
    check("t1_in_load", 32'(dbg_state), 32'd1);
    check("t1_load_we", 32'(tx_pdu_octet_mem_we), 32'd1);
    adv_enable = 1'b0;
    tick();
    check("t1_abort_idle", 32'(dbg_state), 32'd0);
    check("t1_abort_we", 32'(tx_pdu_octet_mem_we), 32'd0);
    check("t1_abort_busy", 32'(adv_busy), 32'd0);

    // Single channel 38
    clear_logs();
    pdu_len = 6'd2; adv_chan_map = 3'b010; adv_interval_cycles = 24'd500; phy_delay = 20;
    adv_enable = 1'b1;
    wait_ed("t2_event_done_wait", 200);
    check("t2_start_count", 32'(start_ch_q.size()), 32'd1);
    check("t2_ch", 32'(q_at(start_ch_q, 0)), 32'd38);
    check("t2_aa", tx_access_address, 32'h8E89BED6);
    check("t2_crc", 32'(tx_crc_state_init_bit), 32'h555555);
    check("t2_preamble", 32'(tx_preamble), 32'hAA);
    check("t2_no_gap", 32'(gap_seen), 32'd0);
    check("t2_wait_interval", 32'(dbg_state), 32'd6);
    stop_and_check_idle("t2_idle");

    // PHY silent: timeout
    clear_logs();
    adv_chan_map = 3'b001; adv_interval_cycles = 24'd1000; phy_delay = 0;
    adv_enable = 1'b1;
    wait_ed("t3_event_done_wait", 300);
    check("t3_timeout_count", 32'(to_cnt), 32'd1);
    check("t3_timeout_latency", 32'(to_cyc - q_at(start_cyc_q, 0)), 32'd101);
    check("t3_done_with_timeout", 32'(ed_cyc), 32'(to_cyc));
    stop_and_check_idle("t3_idle");

    // PHY done on the last WAIT_TX cycle: no timeout pulse
    clear_logs();
    phy_delay = 100;
    adv_enable = 1'b1;
    wait_ed("t3b_event_done_wait", 300);
    check("t3b_no_timeout", 32'(to_cnt), 32'd0);
    check("t3b_done_latency", 32'(ed_cyc - q_at(start_cyc_q, 0)), 32'd101);
    stop_and_check_idle("t3b_idle");

    // Event longer than the interval
    clear_logs();
    adv_chan_map = 3'b001; adv_interval_cycles = 24'd10; phy_delay = 20;
    adv_enable = 1'b1;
    wait_loads("t4_second_load_wait", 2, 200);
    check("t4_restart_after_done", 32'(q_at(load_cyc_q, 1) - ed_cyc), 32'd1);
    check("t4_load_spacing", 32'(q_at(load_cyc_q, 1) - q_at(load_cyc_q, 0)), 32'd26);
    stop_and_check_idle("t4_idle");

    // Enable dropped during WAIT_TX on channel 37
    clear_logs();
    adv_chan_map = 3'b111; adv_interval_cycles = 24'd2000; phy_delay = 50;
    adv_enable = 1'b1;
    n = 0;
    while (start_ch_q.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    check("t5_start_wait", 32'(start_ch_q.size()), 32'd1);
    adv_enable = 1'b0;
    wait_ed("t5_event_done_wait", 200);
    repeat (20) tick();
    check("t5_done_latency", 32'(ed_cyc - q_at(start_cyc_q, 0)), 32'd51);
    check("t5_single_start", 32'(start_ch_q.size()), 32'd1);
    check("t5_no_gap", 32'(gap_seen), 32'd0);
    check("t5_idle", 32'(dbg_state), 32'd0);

    // Reset during LOAD
    clear_logs();
    pdu_len = 6'd8; adv_chan_map = 3'b111;
    adv_enable = 1'b1;
    n = 0;
    while (dbg_state != 3'd1 && n < 20) begin
      tick();
      n++;
    end
    check("t6_load_wait", 32'(dbg_state), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t6_state", 32'(dbg_state), 32'd0);
    check("t6_busy", 32'(adv_busy), 32'd0);
    check("t6_we", 32'(tx_pdu_octet_mem_we), 32'd0);
    check("t6_mem_data", 32'(tx_pdu_octet_mem_data), 32'd0);
    check("t6_buf_addr", 32'(pdu_buf_addr), 32'd0);
    check("t6_channel", 32'(tx_channel_number), 32'd0);
    check("t6_preamble", 32'(tx_preamble), 32'd0);
    check("t6_crc", 32'(tx_crc_state_init_bit), 32'd0);
    rst = 1'b0;
    adv_chan_map = 3'b000;
    repeat (5) tick();
    check("t6_map0_idle", 32'(dbg_state), 32'd0);
    check("t6_map0_busy", 32'(adv_busy), 32'd0);
    check("t6_no_event_done", 32'(ed_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
